// File: rtl/eco_chk_pkg.sv
// eco_chk_pkg: shared types, sizes and the ECO-patched golden function for the sweep checker.
package eco_chk_pkg;
   localparam int W     = 3;
   localparam int NVEC  = 1 << (2 * W);
   localparam int CNT_W = 2 * W + 1;
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;
   // bits above 0 are plain NOR; bit 0 carries the ECO XOR with ~a[0]
   function automatic logic [W-1:0] eco_gold(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] g;
      g = ~(a | b);
      g[0] = ~(a[0] | b[0]) ^ ~a[0];
      return g;
   endfunction
endpackage

// File: rtl/eco_golden_model.sv
// eco_golden_model: combinational golden reference for the patched gate network.
module eco_golden_model
   import eco_chk_pkg::*;
(
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = eco_gold(a_i, b_i);
endmodule

// File: rtl/eco_sweep_checker.sv
// eco_sweep_checker: drives every {a,b} vector into the DUT, waits SETTLE cycles,
// compares against the golden model and records error count and first failure.
module eco_sweep_checker
   import eco_chk_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [W-1:0]       stim_a,
   output logic [W-1:0]       stim_b,
   input  logic [W-1:0]       dut_y,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   err_count,
   output logic               fail_valid,
   output logic [2*W-1:0]     first_fail_vec,
   output logic [W-1:0]       first_fail_y
);
   state_e             state_q;
   logic [2*W-1:0]     v_q;
   logic [3:0]         settle_q;
   logic [CNT_W-1:0]   err_q;
   logic               busy_q, done_q, fail_q;
   logic [2*W-1:0]     ffv_q;
   logic [W-1:0]       ffy_q;
   logic [W-1:0]       gold_d;
   logic               mismatch_d;

   eco_golden_model u_gold (.a_i(stim_a), .b_i(stim_b), .y_o(gold_d));

   assign mismatch_d = dut_y != gold_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         v_q      <= '0;
         settle_q <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
         ffv_q    <= '0;
         ffy_q    <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: if (start) begin
               state_q  <= APPLY;
               v_q      <= '0;
               settle_q <= '0;
               err_q    <= '0;
               fail_q   <= 1'b0;
               ffv_q    <= '0;
               ffy_q    <= '0;
               busy_q   <= 1'b1;
               done_q   <= 1'b0;
            end
            APPLY: if (settle_q == 4'(SETTLE - 1)) begin
               settle_q <= '0;
               state_q  <= CHECK;
            end else begin
               settle_q <= settle_q + 4'd1;
            end
            CHECK: begin
               if (mismatch_d && err_q != CNT_W'(NVEC)) err_q <= err_q + 1'b1;
               if (mismatch_d && !fail_q) begin
                  fail_q <= 1'b1;
                  ffv_q  <= v_q;
                  ffy_q  <= dut_y;
               end
               // the terminal vector ends the sweep so v never wraps
               if (&v_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  v_q     <= v_q + 1'b1;
                  state_q <= APPLY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stim_a         = v_q[2*W-1:W];
   assign stim_b         = v_q[W-1:0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = done_q && err_q == '0;
   assign err_count      = err_q;
   assign fail_valid     = fail_q;
   assign first_fail_vec = ffv_q;
   assign first_fail_y   = ffy_q;
endmodule

// File: tb/tb_eco_sweep_checker.sv
// tb_eco_sweep_checker: directed sweeps against patched, unpatched and stuck-zero DUT models.
module tb_eco_sweep_checker;
   logic clk = 0, rst_n = 0, start1 = 0, start3 = 0;
   int   mode = 0;
   int   n_chk = 0, n_fail = 0;
   int   cyc;
   logic [2:0] sa1, sb1, y1, sa3, sb3, y3, ffy1, ffy3;
   logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
   logic [6:0] err1, err3;
   logic [5:0] ffv1, ffv3;

   always #5 clk = ~clk;

   function automatic logic [2:0] dut_fn(input int m, input logic [2:0] a, input logic [2:0] b);
      if (m == 0) return {~(a[2] | b[2]), ~(a[1] | b[1]), ~a[0] & b[0]};
      if (m == 1) return ~(a | b);
      return 3'b000;
   endfunction

   assign y1 = dut_fn(mode, sa1, sb1);
   assign y3 = dut_fn(mode, sa3, sb3);

   eco_sweep_checker #(.SETTLE(1)) d1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stim_a(sa1), .stim_b(sb1), .dut_y(y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
      .first_fail_vec(ffv1), .first_fail_y(ffy1));

   eco_sweep_checker #(.SETTLE(3)) d3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .stim_a(sa3), .stim_b(sb3), .dut_y(y3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3),
      .first_fail_vec(ffv3), .first_fail_y(ffy3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sweep(input bit s3, input bit hold, output int c);
      @(negedge clk);
      if (s3) start3 = 1; else start1 = 1;
      @(posedge clk); #1;
      if (!hold) begin start1 = 0; start3 = 0; end
      check("busy_after_start", s3 ? busy3 : busy1, 1);
      c = 0;
      while (c < 2000) begin
         @(posedge clk); c++; #1;
         if (s3 ? done3 : done1) break;
      end
      start1 = 0; start3 = 0;
      check("sweep_terminates", s3 ? done3 : done1, 1);
   endtask

   task automatic check_zero1(input string tag);
      check(tag, {busy1, done1, pass1, fv1, sa1, sb1, err1, ffv1, ffy1}, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_zero1("reset_outputs");
      check("reset_outputs_s3", {busy3, done3, pass3, fv3, sa3, sb3, err3, ffv3, ffy3}, 0);
      @(negedge clk) rst_n = 1;
      repeat (2) @(posedge clk);
      #1 check_zero1("idle_after_reset");

      mode = 0;
      sweep(0, 0, cyc);
      check("patched_cycles", cyc, 128);
      check("patched_pass", pass1, 1);
      check("patched_err", err1, 0);
      check("patched_fv", fv1, 0);
      check("patched_busy_done", busy1, 0);

      mode = 1;
      sweep(0, 0, cyc);
      check("unpatched_cycles", cyc, 128);
      check("unpatched_err", err1, 32);
      check("unpatched_ffv", ffv1, 6'b000000);
      check("unpatched_ffy", ffy1, 3'b111);
      check("unpatched_fv", fv1, 1);
      check("unpatched_pass", pass1, 0);
      check("unpatched_stim_held", {sa1, sb1}, 6'b111111);

      mode = 2;
      sweep(0, 0, cyc);
      check("zero_err", err1, 37);
      check("zero_ffv", ffv1, 0);
      check("zero_ffy", ffy1, 3'b000);
      check("zero_pass", pass1, 0);

      mode = 0;
      @(negedge clk) start1 = 1;
      @(posedge clk); #1 start1 = 0;
      repeat (50) @(posedge clk);
      @(negedge clk) rst_n = 0;
      #1 check_zero1("midsweep_reset");
      @(negedge clk) rst_n = 1;
      sweep(0, 0, cyc);
      check("after_reset_cycles", cyc, 128);
      check("after_reset_pass", pass1, 1);
      check("after_reset_err", err1, 0);

      mode = 1;
      sweep(0, 1, cyc);
      check("held_start_cycles", cyc, 128);
      check("held_start_err", err1, 32);
      @(posedge clk); #1;
      check("held_start_stays_done", done1, 1);
      sweep(0, 0, cyc);
      check("restart_err", err1, 32);
      check("restart_ffy", ffy1, 3'b111);

      mode = 0;
      sweep(1, 0, cyc);
      check("settle3_cycles", cyc, 256);
      check("settle3_pass", pass3, 1);
      mode = 1;
      sweep(1, 0, cyc);
      check("settle3_unpatched_err", err3, 32);
      check("settle3_unpatched_ffy", ffy3, 3'b111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
